mem_port: RTL and testbench
===========================

MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8, at least 8.
REQ-002 SHALL have parameter DEPTH_LOG, default 10, log2 of word count.
REQ-003 SHALL have parameter BASE, default 16'h1000, required value of req_addr[31:16] for an in-range access.
REQ-004 SHALL have parameter READ_LAT, default 1, response latency in cycles; legal values 1 or 2.
REQ-005 SHALL have parameter INIT_FILE, default "", hex image loaded at elaboration; empty means no load.
REQ-006 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high.
REQ-010 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port req_be, input, DATA_W/8, byte enables for writes.
REQ-012 SHALL have port req_addr, input, 32, byte address.
REQ-013 SHALL have port req_wdata, input, DATA_W, write data.
REQ-014 SHALL have port rsp_valid, output, 1, response present.
REQ-015 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both high.
REQ-016 SHALL have port rsp_rdata, output, DATA_W, read data; 0 for writes and errors.
REQ-017 SHALL have port rsp_err, output, 1, request was out of range or misaligned.
REQ-018 SHALL have port cnt_rd, output, 16, count of successful reads.
REQ-019 SHALL have port cnt_wr, output, 16, count of successful writes.
REQ-020 SHALL have port cnt_err, output, 16, count of error responses.

Function
REQ-021 SHALL hold 2^DEPTH_LOG words of DATA_W bits.
REQ-022 SHALL index words with req_addr[A+DEPTH_LOG-1:A], where A = log2(DATA_W/8).
REQ-023 SHALL flag a request as error when req_addr[31:16] != BASE, or when req_addr[A-1:0] != 0 (A > 0).
REQ-024 SHALL produce exactly one response per accepted request, in order, for reads and writes alike.
REQ-025 SHALL present the response READ_LAT cycles after acceptance when there is no backpressure.
REQ-026 SHALL pipeline the block in READ_LAT stages that advance only when stall = rsp_valid & ~rsp_ready is low; req_ready = ~stall (combinational).
REQ-027 SHALL, while stalled, hold rsp_valid, rsp_rdata and rsp_err stable, leave memory unchanged and perform no new array read.
REQ-028 SHALL sustain one request per cycle with rsp_ready held high.
REQ-029 SHALL, on an accepted non-error write, update only the bytes whose req_be bit is set, at the acceptance edge.
REQ-030 SHALL treat a write with req_be all zero as a successful no-op write (counted, no error).
REQ-031 SHALL return, for a read accepted the cycle after a write to the same word, the post-write data.
REQ-032 SHALL, for an error request, leave memory unchanged, return rsp_err=1 with rsp_rdata=0, and not read the array.
REQ-033 SHALL increment cnt_rd, cnt_wr or cnt_err by 1 when the matching response is consumed (rsp_valid & rsp_ready).
REQ-034 SHALL saturate each counter at 16'hFFFF.
REQ-035 SHALL, with INIT_FILE non-empty, load it with $readmemh at elaboration; otherwise contents are undefined until written.
REQ-036 SHALL ignore req_we, req_be, req_addr and req_wdata when req_valid is low.

Reset
REQ-037 SHALL, while reset_n is low, force rsp_valid=0, rsp_err=0, rsp_rdata=0 and all counters to 0, and clear all pipeline valid bits.
REQ-038 SHALL drop in-flight requests on reset assertion mid-operation with no response after release; writes already accepted remain in memory.
REQ-039 SHALL not clear memory contents on reset.
REQ-040 SHALL have req_ready=1 during and immediately after reset.

Verification
REQ-041 Bench SHALL cover: DATA_W=32, READ_LAT=1: write 0x1000_0010 / 0xDEADBEEF / be=4'hF, then read 0x1000_0010 -> rsp_rdata=0xDEADBEEF one cycle after acceptance, rsp_err=0, cnt_wr=1, cnt_rd=1.
REQ-042 Bench SHALL cover: byte enables: word holds 0xDEADBEEF; write 0x11223344 with be=4'b0101 -> subsequent read returns 0xDE22BE44.
REQ-043 Bench SHALL cover: errors: read 0x2000_0000 -> rsp_err=1, rsp_rdata=0; write 0x1000_0002 -> rsp_err=1, memory unchanged; cnt_err=2.
REQ-044 Bench SHALL cover: backpressure, READ_LAT=2: back-to-back reads with rsp_ready low 3 cycles -> req_ready low while stalled, rsp stable, no loss or reorder, one response per request.
REQ-045 Bench SHALL cover: reset_n pulsed low with 2 reads in flight -> rsp_valid=0 asynchronously, counters=0, no responses after release, earlier written data still readable.
REQ-046 Bench SHALL cover: counter saturation: force 65536 successful writes -> cnt_wr=16'hFFFF.

Source files
------------

// File: rtl/mem_port.sv
// Single-port word memory behind valid/ready request and response channels.
// A READ_LAT-deep pipeline carries every request to its response and freezes as a whole on stall.
module mem_port #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH_LOG = 10,
    parameter logic [15:0] BASE      = 16'h1000,
    parameter int unsigned READ_LAT  = 1,
    parameter              INIT_FILE = ""
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [15:0]         cnt_rd,
    output logic [15:0]         cnt_wr,
    output logic [15:0]         cnt_err
);
    localparam int unsigned NB         = DATA_W / 8;
    localparam int unsigned A          = $clog2(NB);
    localparam int unsigned WORDS      = 1 << DEPTH_LOG;
    localparam logic [31:0] ALIGN_MASK = 32'((1 << A) - 1);

    logic [DATA_W-1:0]    mem [WORDS];
    logic [DEPTH_LOG-1:0] req_idx;
    logic                 req_bad;
    logic                 stall;
    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic                 consume;
    logic                 unused_addr;

    logic [READ_LAT-1:0]  st_valid;
    logic [READ_LAT-1:0]  st_err;
    logic [READ_LAT-1:0]  st_we;
    logic [DATA_W-1:0]    st_data [READ_LAT];

    assign req_idx     = req_addr[A +: DEPTH_LOG];
    assign unused_addr = ^req_addr;
    assign req_bad     = (req_addr[31:16] != BASE) || ((req_addr & ALIGN_MASK) != '0);

    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~stall;
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_we & ~req_bad;
    assign rd_en     = accept & ~req_we & ~req_bad;
    assign consume   = rsp_valid & rsp_ready;

    assign rsp_valid = st_valid[READ_LAT-1];
    assign rsp_err   = st_err[READ_LAT-1];
    assign rsp_rdata = st_data[READ_LAT-1];

    // Writes are gated by reset_n so nothing lands in the array while held in reset.
    always_ff @(posedge clock) begin
        if (reset_n && wr_en) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (req_be[b]) begin
                    mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the request (and read data) at acceptance; later stages only delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_valid <= '0;
            st_err   <= '0;
            st_we    <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                st_data[i] <= '0;
            end
        end else if (!stall) begin
            st_valid   <= (st_valid << 1) | READ_LAT'(req_valid);
            st_err     <= (st_err << 1) | READ_LAT'(req_valid & req_bad);
            st_we      <= (st_we << 1) | READ_LAT'(req_valid & req_we);
            st_data[0] <= rd_en ? mem[req_idx] : '0;
            for (int i = int'(READ_LAT) - 1; i > 0; i--) begin
                st_data[i] <= st_data[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_err <= '0;
        end else if (consume) begin
            if (rsp_err) begin
                if (cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
            end else if (st_we[READ_LAT-1]) begin
                if (cnt_wr != 16'hFFFF) cnt_wr <= cnt_wr + 16'd1;
            end else begin
                if (cnt_rd != 16'hFFFF) cnt_rd <= cnt_rd + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: instances with READ_LAT 1 and 2 share stimulus, each checked every
// cycle against a queue model of outstanding responses, plus directed literal expectations.
module tb_mem_port;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_we;
    logic        rsp_ready;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy  [2];
    logic        rvld [2];
    logic        rerr [2];
    logic [31:0] rdata [2];
    logic [15:0] c_rd [2];
    logic [15:0] c_wr [2];
    logic [15:0] c_er [2];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clock = ~clock;

    mem_port #(
        .DATA_W(32), .DEPTH_LOG(10), .BASE(16'h1000), .READ_LAT(1), .INIT_FILE("")
    ) u_lat1 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rvld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[0]), .rsp_err(rerr[0]),
        .cnt_rd(c_rd[0]), .cnt_wr(c_wr[0]), .cnt_err(c_er[0])
    );

    mem_port #(
        .DATA_W(32), .DEPTH_LOG(10), .BASE(16'h1000), .READ_LAT(2), .INIT_FILE("")
    ) u_lat2 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rvld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata[1]), .rsp_err(rerr[1]),
        .cnt_rd(c_rd[1]), .cnt_wr(c_wr[1]), .cnt_err(c_er[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got 0x%0h, want 0x%0h", name, k, $time, act, exp);
        end
    endtask

    // Model: each accepted request becomes an entry that ages once per unstalled edge and is
    // visible at the head once its age reaches the latency.
    typedef struct packed {
        int          age;
        logic        err;
        logic        we;
        logic [31:0] data;
    } ent_t;

    ent_t        q [2][$];
    logic [31:0] mm [2][16];
    int unsigned mcnt [2][3];

    task automatic model_cycle(input int k);
        int   lat;
        int   t;
        logic vis;
        logic stall;
        ent_t e;
        logic [3:0] w;
        lat = k + 1;
        if (!reset_n) begin
            q[k].delete();
            for (int i = 0; i < 3; i++) mcnt[k][i] = 0;
        end
        vis   = (q[k].size() > 0) && (q[k][0].age == lat);
        stall = vis && !rsp_ready;
        check("req_ready", k, 32'(rdy[k]), 32'(!stall));
        check("rsp_valid", k, 32'(rvld[k]), 32'(vis));
        if (vis) begin
            check("rsp_err", k, 32'(rerr[k]), 32'(q[k][0].err));
            check("rsp_rdata", k, rdata[k], q[k][0].data);
        end
        check("cnt_rd", k, 32'(c_rd[k]), mcnt[k][0]);
        check("cnt_wr", k, 32'(c_wr[k]), mcnt[k][1]);
        check("cnt_err", k, 32'(c_er[k]), mcnt[k][2]);
        if (!reset_n || stall) return;
        if (vis) begin
            e = q[k].pop_front();
            t = e.err ? 2 : (e.we ? 1 : 0);
            if (mcnt[k][t] < 32'hFFFF) mcnt[k][t]++;
        end
        for (int i = 0; i < q[k].size(); i++) begin
            e = q[k][i];
            e.age = e.age + 1;
            q[k][i] = e;
        end
        if (req_valid) begin
            e.age  = 1;
            e.err  = (req_addr[31:16] != 16'h1000) || (req_addr[1:0] != 2'b00);
            e.we   = req_we;
            e.data = '0;
            w      = req_addr[5:2];
            if (!e.err && req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_be[b]) mm[k][w][8*b +: 8] = req_wdata[8*b +: 8];
                end
            end else if (!e.err) begin
                e.data = mm[k][w];
            end
            q[k].push_back(e);
        end
    endtask

    always @(negedge clock) begin
        model_cycle(0);
        model_cycle(1);
    end

    task automatic drive(input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = a;
        req_wdata = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int   sent;
        int   cyc;
        logic acc;
        int   sel;
        logic [31:0] a;

        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rsp_valid", 0, 32'(rvld[0]), 32'd0);
        check("rst_req_ready", 0, 32'(rdy[0]), 32'd1);
        check("rst_cnt_wr", 1, 32'(c_wr[1]), 32'd0);
        reset_n = 1'b1;
        check("rel_req_ready", 1, 32'(rdy[1]), 32'd1);

        // Write then read back with one-cycle latency on the READ_LAT=1 instance.
        drive(1'b1, 1'b1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 4'h0, 32'h1000_0010, 32'h0);
        check("basic_valid", 0, 32'(rvld[0]), 32'd1);
        check("basic_rdata", 0, rdata[0], 32'hDEAD_BEEF);
        check("basic_err", 0, 32'(rerr[0]), 32'd0);
        idle(2);
        check("basic_cnt_wr", 0, 32'(c_wr[0]), 32'd1);
        check("basic_cnt_rd", 0, 32'(c_rd[0]), 32'd1);
        check("basic_cnt_wr", 1, 32'(c_wr[1]), 32'd1);
        check("basic_cnt_rd", 1, 32'(c_rd[1]), 32'd1);

        drive(1'b1, 1'b1, 4'b0101, 32'h1000_0010, 32'h1122_3344);
        drive(1'b1, 1'b0, 4'h0, 32'h1000_0010, 32'h0);
        check("be_merge", 0, rdata[0], 32'hDE22_BE44);
        idle(2);

        for (int i = 0; i < 16; i++) begin
            if (i != 4) drive(1'b1, 1'b1, 4'hF, 32'h1000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
        end
        idle(2);

        drive(1'b1, 1'b0, 4'h0, 32'h2000_0000, 32'h0);
        check("err_rd_err", 0, 32'(rerr[0]), 32'd1);
        check("err_rd_data", 0, rdata[0], 32'h0);
        drive(1'b1, 1'b1, 4'hF, 32'h1000_0002, 32'hFFFF_FFFF);
        check("err_wr_err", 0, 32'(rerr[0]), 32'd1);
        drive(1'b1, 1'b0, 4'h0, 32'h1000_0000, 32'h0);
        check("err_wr_nochange", 0, rdata[0], 32'hC0DE_0000);
        idle(2);
        check("err_cnt", 0, 32'(c_er[0]), 32'd2);
        check("err_cnt", 1, 32'(c_er[1]), 32'd2);

        // Backpressure on the READ_LAT=2 instance: requests held until it accepts them.
        sent = 0;
        cyc  = 0;
        while (sent < 4 && cyc < 40) begin
            rsp_ready = !(cyc >= 2 && cyc < 5);
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_be    = 4'h0;
            req_addr  = 32'h1000_0000 + 32'((sent + 8) * 4);
            req_wdata = 32'h0;
            @(negedge clock);
            if (!rsp_ready && rvld[1]) check("stall_req_ready", 1, 32'(rdy[1]), 32'd0);
            acc = rdy[1];
            @(posedge clock);
            #1;
            if (acc) sent++;
            cyc++;
        end
        rsp_ready = 1'b1;
        if (sent < 4) check("bp_accepted", 1, 32'(sent), 32'd4);
        idle(4);
        check("bp_cnt_rd", 1, 32'(c_rd[1]), 32'd7);

        // Reset with two reads in flight on the READ_LAT=2 instance.
        drive(1'b1, 1'b0, 4'h0, 32'h1000_0000, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h1000_0004, 32'h0);
        check("inflight_valid", 1, 32'(rvld[1]), 32'd1);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("async_rst_valid", 1, 32'(rvld[1]), 32'd0);
        check("async_rst_valid", 0, 32'(rvld[0]), 32'd0);
        check("async_rst_cnt_rd", 1, 32'(c_rd[1]), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(6);
        drive(1'b1, 1'b0, 4'h0, 32'h1000_0010, 32'h0);
        check("post_rst_data", 0, rdata[0], 32'hDE22_BE44);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            a   = 32'h1000_0000 + 32'($urandom_range(0, 15) * 4);
            if (sel == 8) a = a + 32'($urandom_range(1, 3));
            else if (sel == 9) a = {16'h1000 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
            rsp_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), a,
                  $urandom);
        end
        rsp_ready = 1'b1;
        idle(4);

        for (int n = 0; n < 65540; n++) begin
            drive(1'b1, 1'b1, 4'($urandom), 32'h1000_0000 + 32'((n % 16) * 4), $urandom);
        end
        idle(3);
        check("cnt_wr_sat", 0, 32'(c_wr[0]), 32'h0000_FFFF);
        check("cnt_wr_sat", 1, 32'(c_wr[1]), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
